// File: rtl/dram_reader.sv
// dram_reader: streaming read sequencer for the dram distributed RAM.
//
// A start command makes the block walk a contiguous address range. The
// range wraps at RAM_DEPTH. For each address it drives raddr, captures the
// combinational rdata returned by dram, and presents the words in address
// order on a valid/ready stream. m_last marks the final word of the command.
//
// Ports:
//   clk       in   clock, rising edge (shared with the attached dram)
//   rstn      in   asynchronous active-low reset
//   start     in   command strobe, only looked at while idle
//   base_addr in   first address of the command (< RAM_DEPTH)
//   length    in   number of words to read; zero gives an immediate done
//   busy      out  command in progress
//   done      out  one-cycle pulse when a command has completed
//   raddr     out  registered read address to dram
//   rdata     in   read data from dram (combinational read of raddr)
//   m_data    out  stream data
//   m_valid   out  stream valid
//   m_ready   in   stream ready from the consumer
//   m_last    out  final word of the command
module dram_reader #(
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_DEPTH      = 16,
  parameter int RAM_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [RAM_ADDR_WIDTH-1:0] base_addr,
  input  logic [RAM_ADDR_WIDTH:0]   length,
  output logic                      busy,
  output logic                      done,
  output logic [RAM_ADDR_WIDTH-1:0] raddr,
  input  logic [RAM_WIDTH-1:0]      rdata,
  output logic [RAM_WIDTH-1:0]      m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [RAM_ADDR_WIDTH:0]   rem_q, rem_d;
  logic [RAM_WIDTH-1:0]      data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      last_q, last_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      load;

  // The output register takes a new word when it is empty or when its
  // current word is being accepted, so a steady ready gives one word/cycle.
  assign load = !valid_q || m_ready;

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            raddr_d = base_addr;
            rem_d   = length;
            busy_d  = 1'b1;
            state_d = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (load) begin
          data_d  = rdata;
          valid_d = 1'b1;
          last_d  = (rem_q == (RAM_ADDR_WIDTH+1)'(1));
          raddr_d = (raddr_q == RAM_ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0
                                                                : raddr_q + RAM_ADDR_WIDTH'(1);
          rem_d   = rem_q - (RAM_ADDR_WIDTH+1)'(1);
          if (rem_q == (RAM_ADDR_WIDTH+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last word is already in the output register; wait for it
        // to be taken before reporting completion.
        if (valid_q && m_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      raddr_q <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign raddr   = raddr_q;
  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign m_last  = last_q;

endmodule

// File: tb/tb_dram_reader.sv
// Testbench for dram_reader: behavioural dram model, queue-based scoreboard
// of expected stream words, and directed commands for sweep, wrap-around,
// backpressure, zero length, ignored start and reset mid-stream.
module tb_dram_reader;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done;
  logic [AW-1:0] raddr;
  logic [W-1:0]  rdata;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  logic [W-1:0] mem [D];
  assign rdata = mem[raddr];

  always #5 clk = ~clk;

  dram_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RAM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .raddr(raddr),
    .rdata(rdata), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  exp_t          sb[$];
  int            rdy_pat[$];
  logic [AW-1:0] raddr_log[$];
  bit            log_en = 1'b0;
  int            hs_cnt = 0;
  int            stall_cnt = 0;
  bit            prev_stall = 1'b0;
  logic [W-1:0]  prev_d;
  logic          prev_l;

  // Ready driver: follows a queued pattern, otherwise holds ready high.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_ready = (rdy_pat.size() != 0) ? (rdy_pat.pop_front() != 0) : 1'b1;
    end
  end

  // Stream monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      check("done_busy_excl", {63'd0, done & busy}, 64'd0);
      if (prev_stall) begin
        check("stall_valid", {63'd0, m_valid}, 64'd1);
        check("stall_data", {32'd0, m_data}, {32'd0, prev_d});
        check("stall_last", {63'd0, m_last}, {63'd0, prev_l});
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          check("extra_word", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("data", {32'd0, m_data}, {32'd0, e.d});
          check("last", {63'd0, m_last}, {63'd0, e.l});
        end
      end
      if (m_valid && !m_ready) stall_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_l     = m_last;
      if (log_en && busy) raddr_log.push_back(raddr);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_cmd(input int b, input int l);
    int a;
    exp_t e;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(b);
    length    = (AW+1)'(l);
    for (int i = 0; i < l; i++) begin
      a   = (b + i) % D;
      e.d = W'((a + 1) << 1);
      e.l = (i == l - 1);
      sb.push_back(e);
    end
  endtask

  // n is the number of the edge after which done was seen (start at edge 0).
  task automatic run_until_done(output int n, input bit bp, input bit mid);
    bit seen;
    seen = 1'b0;
    n = -1;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(posedge clk);
      n++;
      #1;
      start = 1'b0;
      if (n == 1 && bp) begin
        rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(0);
        rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(1);
        rdy_pat.push_back(1); rdy_pat.push_back(1);
      end
      if (n == 1 && mid) begin
        start     = 1'b1;
        base_addr = AW'(9);
        length    = (AW+1)'(3);
      end
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < D; i++) mem[i] = W'((i + 1) << 1);
    rstn = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    #12;
    check("rst_valid", {63'd0, m_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_last", {63'd0, m_last}, 64'd0);
    check("rst_raddr", {60'd0, raddr}, 64'd0);
    check("rst_data", {32'd0, m_data}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Full sweep
    start_cmd(0, 16);
    run_until_done(n, 1'b0, 1'b0);
    check("sweep_latency", 64'(n), 64'd17);
    check("sweep_busy_at_done", {63'd0, busy}, 64'd0);
    check("sweep_sb_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    check("sweep_done_pulse", {63'd0, done}, 64'd0);

    // Wrap-around
    raddr_log.delete();
    log_en = 1'b1;
    start_cmd(14, 4);
    run_until_done(n, 1'b0, 1'b0);
    log_en = 1'b0;
    check("wrap_latency", 64'(n), 64'd5);
    check("wrap_log_len", 64'(raddr_log.size() >= 4), 64'd1);
    if (raddr_log.size() >= 4) begin
      check("wrap_raddr0", {60'd0, raddr_log[0]}, 64'd14);
      check("wrap_raddr1", {60'd0, raddr_log[1]}, 64'd15);
      check("wrap_raddr2", {60'd0, raddr_log[2]}, 64'd0);
      check("wrap_raddr3", {60'd0, raddr_log[3]}, 64'd1);
    end
    check("wrap_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure
    stall_cnt = 0;
    start_cmd(3, 5);
    run_until_done(n, 1'b1, 1'b0);
    check("bp_stalls", 64'(stall_cnt), 64'd3);
    check("bp_latency", 64'(n), 64'(6 + stall_cnt));
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Zero length
    start_cmd(7, 0);
    run_until_done(n, 1'b0, 1'b0);
    check("zero_latency", 64'(n), 64'd0);
    check("zero_busy", {63'd0, busy}, 64'd0);
    check("zero_valid", {63'd0, m_valid}, 64'd0);
    @(negedge clk);
    check("zero_done_drop", {63'd0, done}, 64'd0);
    check("zero_valid_later", {63'd0, m_valid}, 64'd0);

    // Start asserted mid-command is ignored
    start_cmd(0, 2);
    run_until_done(n, 1'b0, 1'b1);
    check("mid_latency", 64'(n), 64'd3);
    check("mid_sb_empty", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("mid_idle_busy", {63'd0, busy}, 64'd0);
    check("mid_idle_valid", {63'd0, m_valid}, 64'd0);

    // Reset mid-stream
    hs_cnt = 0;
    start_cmd(0, 8);
    for (int k = 0; k < 50 && hs_cnt < 3; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
    end
    check("rst_mid_reached", 64'(hs_cnt >= 3), 64'd1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("rstmid_valid", {63'd0, m_valid}, 64'd0);
    check("rstmid_last", {63'd0, m_last}, 64'd0);
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_done", {63'd0, done}, 64'd0);
    check("rstmid_raddr", {60'd0, raddr}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    start_cmd(5, 2);
    run_until_done(n, 1'b0, 1'b0);
    check("post_rst_latency", 64'(n), 64'd3);
    check("post_rst_sb_empty", 64'(sb.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dram_reader.md
# dram_reader

Streaming read sequencer for the `dram` distributed-RAM block. It is the read-side counterpart to the blocks that fill `dram`. On a start command it walks a contiguous, wrap-around address range, drives `dram.raddr` and captures `dram.dout`. It delivers the words in order on a valid/ready stream with a last flag, which the LSTM datapath uses to pull weight and state vectors out of the RAMs.

## Interface
- RAM_WIDTH, 32, data word width; must match the attached `dram`
- RAM_DEPTH, 16, number of words in the attached `dram`; addresses wrap at this value
- RAM_ADDR_WIDTH, 4, address width; RAM_DEPTH <= 2^RAM_ADDR_WIDTH
- clk  in  1  single clock, rising edge; the attached `dram` uses the same clock
- rstn  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  RAM_ADDR_WIDTH  first address; must be < RAM_DEPTH
- length  in  RAM_ADDR_WIDTH+1  number of words to read, 0 allowed
- busy  out  1  high in READ and DRAIN
- done  out  1  one-cycle pulse after the final word is accepted, or after a zero-length command
- raddr  out  RAM_ADDR_WIDTH  to `dram.raddr`; registered
- rdata  in  RAM_WIDTH  from `dram.dout`; combinational read of `raddr`
- m_data  out  RAM_WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from the consumer
- m_last  out  1  high with the final word of a command

## Operation
- Internal state:
  - FSM with states IDLE, READ, DRAIN.
  - Counter `remaining`, RAM_ADDR_WIDTH+1 bits.
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - raddr=0, remaining=0, m_data=0.
  - m_valid=0, m_last=0, busy=0, done=0.
  - Any in-flight command is discarded.
- IDLE:
  - start=1, length!=0: raddr<=base_addr, remaining<=length, go to READ.
  - start=1, length==0: done<=1 for one cycle, stay in IDLE.
  - start=0: hold.
- Load rule: load = !m_valid | m_ready. The output register is refilled whenever it is empty or its current word is being accepted.
- READ, on each load:
  - m_data<=rdata, m_valid<=1, m_last<=(remaining==1).
  - raddr <= (raddr==RAM_DEPTH-1) ? 0 : raddr+1.
  - remaining <= remaining-1.
  - If remaining==1, go to DRAIN.
- READ without load (m_valid=1, m_ready=0): m_data, m_last, raddr and remaining all hold.
- DRAIN:
  - m_valid=1 and m_ready=1: m_valid<=0, m_last<=0, done<=1 for one cycle, go to IDLE.
  - Otherwise hold.
- Stream rules:
  - Once m_valid=1, m_data and m_last stay stable until the handshake.
  - No word is dropped or duplicated.
  - Words are delivered in address order.
- start is ignored while busy=1.
- length > RAM_DEPTH is legal: the read wraps and re-reads addresses.
- Concurrent writes to `dram`: the captured word is whatever `rdata` shows at the load edge. No hazard handling is done here.

## Timing
- Edge numbering: start is sampled at edge 0.
- Edge 0: raddr=base_addr and busy=1 afterwards.
- Edge 1: m_valid=1 afterwards, with m_data=mem[base].
- Throughput with m_ready held at 1: one word per cycle.
  - The word i handshake is at edge i+2.
  - The last word (L) handshakes at edge L+1.
  - After edge L+1: done=1 and busy=0.
  - done drops after edge L+2.
- Start-to-done latency is L+1 edges plus stall cycles; each cycle with m_valid=1 and m_ready=0 adds one.
- Zero-length command: done=1 after edge 0, busy stays 0, m_valid never rises.
- done and busy are never high in the same cycle.
- A new start may be sampled in the cycle done is high, since the block is already in IDLE.

## Test plan
Preload `dram` with mem[i]=(i+1)<<1, i.e. 2, 4, …, 32.

- Full sweep: base=0, len=16, m_ready=1.
  - Stream is 2, 4, …, 32 on consecutive cycles.
  - m_last=1 only on 32.
  - done is a single pulse 17 edges after start.
  - busy low again at the same edge.
- Wrap-around: base=14, len=4.
  - raddr sequence 14, 15, 0, 1.
  - Stream 30, 32, 2, 4; m_last on 4.
- Backpressure: base=3, len=5, m_ready pattern 1,0,0,1,0,1,1,1 then held at 1.
  - Stream exactly 8, 10, 12, 14, 16.
  - m_data stable during every stall.
  - done only after the 16 handshake.
- Zero length and ignored start:
  - start with len=0 gives a done pulse next cycle, m_valid stays 0, busy stays 0.
  - start asserted mid-command (base=0, len=2) does not disturb the running stream.
- Reset mid-stream: base=0, len=8, rstn pulled low after the 3rd handshake.
  - m_valid, m_last, busy, done and raddr go to 0 immediately.
  - After release, base=5 len=2 gives 12, 14 with m_last on 14.
